// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road intersection sequencer: phase codes,
// signal-head encodings and the phase-to-duration lookup.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5
    } state_e;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    function automatic int unsigned phase_ticks(input state_e s,
                                                input int unsigned green,
                                                input int unsigned yellow,
                                                input int unsigned allred);
        case (s)
            NS_GREEN, EW_GREEN:   return green;
            NS_YELLOW, EW_YELLOW: return yellow;
            default:              return allred;
        endcase
    endfunction

    // Fixed ring; anything unrecognised falls back to the all-red clearance.
    function automatic state_e next_phase(input state_e s);
        case (s)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return RED_A;
            RED_A:     return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            EW_YELLOW: return RED_B;
            RED_B:     return NS_GREEN;
            default:   return RED_B;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Loadable down-counter advanced by the tick enable; a load always wins and
// the count never goes below zero.
module phase_timer #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    // NOTE: reset is sampled on the clock edge only, so it sits inside the
    // if-chain rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= CNT_W'(RST_VAL);
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer. Define TRAFFIC_PED_EN to build the
// pedestrian request latch, green cut and walk interval.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_TICKS   = 50,
    parameter int unsigned YELLOW_TICKS  = 20,
    parameter int unsigned ALLRED_TICKS  = 10,
    parameter int unsigned PED_CUT_TICKS = 10,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ped_req,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [CNT_W-1:0] remain,
    output logic             ped_walk,
    output logic [2:0]       phase
);

    localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_TICKS - 1);

    state_e           state_q, state_d;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt;
    logic             zero;
    logic             is_green;
    logic             ped_cut;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_TICKS - 1)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= RED_B;
        else     state_q <= state_d;
    end

    assign is_green = (state_q == NS_GREEN) || (state_q == EW_GREEN);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            NS_GREEN, NS_YELLOW, RED_A, EW_GREEN, EW_YELLOW, RED_B: begin
                if (tick && zero) begin
                    state_d  = next_phase(state_q);
                    load     = 1'b1;
                    load_val = CNT_W'(phase_ticks(state_d, GREEN_TICKS,
                                                  YELLOW_TICKS, ALLRED_TICKS) - 1);
                end else if (tick && ped_cut) begin
                    load     = 1'b1;
                    load_val = CNT_W'(PED_CUT_TICKS - 1);
                end
            end
            default: begin
                state_d  = RED_B;
                load     = 1'b1;
                load_val = ALLRED_M1;
            end
        endcase
    end

`ifdef TRAFFIC_PED_EN
    logic ped_latch;
    logic ped_served;
    logic walk_q;
    logic enter_red;
    logic leave_red;

    assign enter_red = tick && zero &&
                       (state_q == NS_YELLOW || state_q == EW_YELLOW);
    assign leave_red = tick && zero && (state_q == RED_A || state_q == RED_B);
    assign ped_cut   = is_green && ped_latch &&
                       (cnt > CNT_W'(PED_CUT_TICKS - 1));

    // A request only counts as served once a green has seen it; one raised in
    // yellow/red survives the red entry and is applied to the next green.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_latch  <= 1'b0;
            ped_served <= 1'b0;
            walk_q     <= 1'b0;
        end else if (enter_red) begin
            walk_q     <= ped_served;
            ped_served <= 1'b0;
            ped_latch  <= ped_served ? ped_req : (ped_latch | ped_req);
        end else begin
            if (leave_red)            walk_q     <= 1'b0;
            if (ped_req)              ped_latch  <= 1'b1;
            if (is_green && ped_latch) ped_served <= 1'b1;
        end
    end

    assign ped_walk = walk_q;
`else
    logic ped_req_unused;

    assign ped_req_unused = ped_req;
    assign ped_cut        = 1'b0;
    assign ped_walk       = 1'b0;
`endif

    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        case (state_q)
            NS_GREEN:  ns_light = LIGHT_GRN;
            NS_YELLOW: ns_light = LIGHT_YEL;
            EW_GREEN:  ew_light = LIGHT_GRN;
            EW_YELLOW: ew_light = LIGHT_YEL;
            default:   ;
        endcase
    end

    assign remain = cnt;
    assign phase  = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed self-checking bench for traffic_phase_ctrl with short durations
// (green 5, yellow 2, all-red 1, pedestrian cut 2).
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [7:0] remain;
    logic       ped_walk;
    logic [2:0] phase;

    int n_checks = 0;
    int n_bad    = 0;
    logic       mon_en = 1'b0;
    logic [2:0] prev_ns = 3'b100;
    logic [2:0] prev_ew = 3'b100;

    // Hand-derived sequence after each tick, starting from RED_B after reset.
    int exp_ph[16] = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4, 5};
    int exp_rm[16] = '{4, 3, 2, 1, 0, 1, 0, 0, 4, 3, 2, 1, 0, 1, 0, 0};

    traffic_phase_ctrl #(
        .GREEN_TICKS   (5),
        .YELLOW_TICKS  (2),
        .ALLRED_TICKS  (1),
        .PED_CUT_TICKS (2),
        .CNT_W         (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .remain   (remain),
        .ped_walk (ped_walk),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] lights_for(input int p);
        case (p)
            0:       return {3'b001, 3'b100};
            1:       return {3'b010, 3'b100};
            3:       return {3'b100, 3'b001};
            4:       return {3'b100, 3'b010};
            default: return {3'b100, 3'b100};
        endcase
    endfunction

    task automatic check_state(input string tag, input int ph, input int rm);
        logic [5:0] l;
        l = lights_for(ph);
        check({tag, "_phase"}, phase, ph);
        check({tag, "_remain"}, remain, rm);
        check({tag, "_ns"}, ns_light, l[5:3]);
        check({tag, "_ew"}, ew_light, l[2:0]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One tick pulse followed by quiet cycles; returns on a falling edge.
    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        idle(8);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("heads_exclusive", int'(ns_light != 3'b100 && ew_light != 3'b100), 0);
            if (prev_ns == 3'b001 && ns_light != 3'b001) check("ns_green_to_yellow", ns_light, 3'b010);
            if (prev_ew == 3'b001 && ew_light != 3'b001) check("ew_green_to_yellow", ew_light, 3'b010);
        end
        prev_ns <= ns_light;
        prev_ew <= ew_light;
    end

    initial begin
        apply_reset();
        check_state("reset", 5, 0);
        check("reset_walk", ped_walk, 0);

        // Three full periods, checked per tick and every cycle by the monitor.
        mon_en = 1'b1;
        for (int k = 0; k < 48; k++) begin
            do_tick();
            check_state($sformatf("seq%0d", k), exp_ph[k % 16], exp_rm[k % 16]);
        end
        mon_en = 1'b0;

        // No ticks: everything holds.
        idle(100);
        check_state("hold", 5, 0);

        // Tick held three cycles counts as three ticks.
        @(negedge clk);
        tick = 1'b1;
        idle(3);
        tick = 1'b0;
        idle(2);
        check_state("burst", 0, 2);

        // Reset beats a coincident tick in EW_GREEN.
        apply_reset();
        for (int k = 0; k < 9; k++) do_tick();
        check_state("pre_rst", 3, 4);
        @(negedge clk);
        rst  = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        tick = 1'b0;
        check_state("rst_tick", 5, 0);
        do_tick();
        check_state("post_rst", 0, 4);

`ifdef TRAFFIC_PED_EN
        // Request in NS_GREEN with remain 4 cuts the green to two ticks.
        apply_reset();
        do_tick();
        check_state("ped_g", 0, 4);
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        idle(3);
        do_tick();
        check_state("ped_cut1", 0, 1);
        do_tick();
        check_state("ped_cut0", 0, 0);
        do_tick();
        check_state("ped_y", 1, 1);
        check("ped_y_walk", ped_walk, 0);
        do_tick();
        do_tick();
        check_state("ped_reda", 2, 0);
        check("ped_reda_walk", ped_walk, 1);
        idle(5);
        check("ped_reda_walk_late", ped_walk, 1);
        do_tick();
        check_state("ped_ewg", 3, 4);
        check("ped_ewg_walk", ped_walk, 0);
        do_tick();
        check_state("ped_ewg_nocut", 3, 3);

        // Request during NS_YELLOW: yellow untouched, cut lands in EW_GREEN.
        apply_reset();
        for (int k = 0; k < 6; k++) do_tick();
        check_state("ped2_y", 1, 1);
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        do_tick();
        check_state("ped2_yfull", 1, 0);
        do_tick();
        check_state("ped2_reda", 2, 0);
        check("ped2_reda_walk", ped_walk, 0);
        do_tick();
        check_state("ped2_ewg", 3, 4);
        do_tick();
        check_state("ped2_ewcut", 3, 1);
        do_tick();
        do_tick();
        do_tick();
        do_tick();
        check_state("ped2_redb", 5, 0);
        check("ped2_redb_walk", ped_walk, 1);
        do_tick();
        check_state("ped2_nsg", 0, 4);
        check("ped2_nsg_walk", ped_walk, 0);
`else
        // Feature absent: requests do nothing.
        apply_reset();
        do_tick();
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        idle(3);
        do_tick();
        check_state("noped_g", 0, 3);
        for (int k = 0; k < 6; k++) do_tick();
        check_state("noped_reda", 2, 0);
        check("noped_walk", ped_walk, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
